// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: AXI-lite read master with credit-limited outstanding fetches
// and a registered prefetch queue feeding the decoder over valid/ready.
module ifu_prefetch #(
    parameter int unsigned     XLEN       = 64,
    parameter int unsigned     ADDR_W     = 32,
    parameter int unsigned     DATA_W     = 64,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter int unsigned     MAX_OUT    = 2,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              intr_valid,
    input  logic [XLEN-1:0]   intr_pc,
    input  logic              jump_valid,
    input  logic [XLEN-1:0]   jump_pc,
    output logic              arvalid,
    output logic [ADDR_W-1:0] araddr,
    input  logic              arready,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              rready,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_fault
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] MaxOut = CW'(MAX_OUT);
    localparam logic [CW:0]   Depth  = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [31:0]     mem_inst_q  [FIFO_DEPTH];
    logic [XLEN-1:0] mem_pc_q    [FIFO_DEPTH];
    logic            mem_fault_q [FIFO_DEPTH];

    logic            redir, ar_hs, ar_stall, push, drop, pop;
    logic [XLEN-1:0] redir_pc;
    logic [31:0]     inst_sel;

    // Credit covers both in-flight fetches and queued entries, so a push never overflows.
    assign arvalid = ~rst & (inflight_q < MaxOut) &
                     (({1'b0, inflight_q} + {1'b0, count_q}) < Depth);
    assign araddr  = fetch_pc_q[ADDR_W-1:0];
    assign rready  = 1'b1;

    assign redir    = intr_valid | jump_valid;
    assign redir_pc = intr_valid ? intr_pc : jump_pc;
    assign ar_hs    = arvalid & arready;
    assign ar_stall = arvalid & ~arready;
    assign drop     = rvalid & (drop_cnt_q != '0);
    assign push     = rvalid & (drop_cnt_q == '0) & ~redir;
    assign pop      = inst_valid & inst_ready & ~redir;
    assign inst_sel = rsp_pc_q[2] ? rdata[63:32] : rdata[31:0];

    assign inst_valid = (count_q != '0);
    assign inst       = mem_inst_q[rd_ptr_q];
    assign inst_pc    = mem_pc_q[rd_ptr_q];
    assign inst_fault = mem_fault_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        rsp_pc_d     = rsp_pc_q;
        inflight_d   = inflight_q;
        drop_cnt_d   = drop_cnt_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;

        if (ar_hs) inflight_d = inflight_d + CW'(1);
        if (rvalid) inflight_d = inflight_d - CW'(1);

        // A stalled AR that outlived a redirect carries a stale address: count it as a drop.
        if (ar_hs) begin
            if (pend_valid_q) begin
                fetch_pc_d   = pend_pc_q;
                pend_valid_d = 1'b0;
                drop_cnt_d   = drop_cnt_d + CW'(1);
            end else begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
        end
        if (drop) drop_cnt_d = drop_cnt_d - CW'(1);

        if (push) begin
            rsp_pc_d = rsp_pc_q + XLEN'(4);
            wr_ptr_d = wr_ptr_q + PW'(1);
            count_d  = count_d + CW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_d - CW'(1);
        end

        if (redir) begin
            drop_cnt_d = inflight_d;
            rsp_pc_d   = redir_pc;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            if (ar_stall) begin
                pend_pc_d    = redir_pc;
                pend_valid_d = 1'b1;
            end else begin
                fetch_pc_d   = redir_pc;
                pend_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            rsp_pc_q     <= RESET_PC;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            inflight_q   <= '0;
            drop_cnt_q   <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            rsp_pc_q     <= rsp_pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            inflight_q   <= inflight_d;
            drop_cnt_q   <= drop_cnt_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_inst_q[i]  <= '0;
                mem_pc_q[i]    <= '0;
                mem_fault_q[i] <= 1'b0;
            end
        end else if (push) begin
            mem_inst_q[wr_ptr_q]  <= inst_sel;
            mem_pc_q[wr_ptr_q]    <= rsp_pc_q;
            mem_fault_q[wr_ptr_q] <= (rresp != 2'b00);
        end
    end

endmodule
